// File: rtl/gcd_lcm_pkg.sv
// ------------------------------------------------------------------
// gcd_lcm_pkg : shared states, register offsets and bit positions
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package gcd_lcm_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_GCD  = 3'd1,
    S_DIV  = 3'd2,
    S_MUL  = 3'd3,
    S_ERR  = 3'd4,
    S_DONE = 3'd5
  } state_t;

  // Word offsets within the register window (DataAdr[4:2])
  localparam logic [2:0] c_OFF_OPA    = 3'd0;
  localparam logic [2:0] c_OFF_OPB    = 3'd1;
  localparam logic [2:0] c_OFF_CTRL   = 3'd2;
  localparam logic [2:0] c_OFF_STATUS = 3'd3;
  localparam logic [2:0] c_OFF_RESULT = 3'd4;

  localparam int c_CTRL_START = 0;
  localparam int c_CTRL_OP    = 1;

  localparam int c_ST_BUSY = 0;
  localparam int c_ST_DONE = 1;
  localparam int c_ST_ERR  = 2;
  localparam int c_ST_OVF  = 3;

endpackage

`default_nettype wire

// File: rtl/gcd_lcm_div.sv
// ------------------------------------------------------------------
// gcd_lcm_div : WIDTH-cycle restoring divider, first step in start cycle
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module gcd_lcm_div #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_quotient,
  output logic             o_valid
);

  localparam int                c_CW   = $clog2(WIDTH);
  localparam logic [c_CW-1:0]   c_ONE  = c_CW'(1);
  localparam logic [c_CW-1:0]   c_LAST = c_CW'(WIDTH - 1);

  logic [WIDTH-1:0] r_rem, r_dq, r_dvs;
  logic [c_CW-1:0]  r_cnt;
  logic             r_run;

  logic [WIDTH-1:0] w_rem_in, w_dq_in, w_dvs, w_rem_nx, w_dq_nx;
  logic [WIDTH:0]   w_trial;
  logic             w_ge;

  // r_dq shifts the dividend out at the top while quotient bits enter at the bottom
  always_comb begin
    w_rem_in = i_start ? '0 : r_rem;
    w_dq_in  = i_start ? i_dividend : r_dq;
    w_dvs    = i_start ? i_divisor : r_dvs;
    w_trial  = {w_rem_in, w_dq_in[WIDTH-1]};
    w_ge     = (w_trial >= {1'b0, w_dvs});
    w_rem_nx = w_ge ? WIDTH'(w_trial - {1'b0, w_dvs}) : w_trial[WIDTH-1:0];
    w_dq_nx  = {w_dq_in[WIDTH-2:0], w_ge};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rem <= '0;
      r_dq  <= '0;
      r_dvs <= '0;
      r_cnt <= '0;
      r_run <= 1'b0;
    end else if (i_start) begin
      r_rem <= w_rem_nx;
      r_dq  <= w_dq_nx;
      r_dvs <= i_divisor;
      r_cnt <= c_ONE;
      r_run <= 1'b1;
    end else if (r_run) begin
      r_rem <= w_rem_nx;
      r_dq  <= w_dq_nx;
      r_cnt <= r_cnt + c_ONE;
      if (r_cnt == c_LAST) r_run <= 1'b0;
    end
  end

  // The final step's result is presented in the same cycle it is computed
  assign o_quotient = w_dq_nx;
  assign o_valid    = r_run && (r_cnt == c_LAST);

endmodule

`default_nettype wire

// File: rtl/gcd_lcm_ctrl.sv
// ------------------------------------------------------------------
// gcd_lcm_ctrl : memory-mapped GCD/LCM coprocessor controller
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module gcd_lcm_ctrl
  import gcd_lcm_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0200,
  parameter int          WIDTH     = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  output logic        cop_hit,
  output logic [31:0] cop_rdata,
  output logic        busy,
  output logic        done_irq
);

  state_t r_state, w_next;

  logic [WIDTH-1:0]   r_opa, r_opb, r_opa_lat, r_opb_lat;
  logic [WIDTH-1:0]   r_a, r_b, r_q, r_result;
  logic               r_op, r_err, r_ovf, r_irq;

  logic [2:0]         w_off;
  logic               w_wr, w_start, w_div_start, w_div_valid;
  logic [WIDTH-1:0]   w_quo;
  logic [2*WIDTH-1:0] w_prod;
  logic               w_unused;

  assign cop_hit  = (DataAdr[31:5] == BASE_ADDR[31:5]);
  assign w_off    = DataAdr[4:2];
  assign w_unused = ^DataAdr[1:0];
  assign w_wr     = MemWrite && cop_hit;
  assign busy     = (r_state != S_IDLE) && (r_state != S_DONE);
  assign w_start  = w_wr && (w_off == c_OFF_CTRL) && WriteData[c_CTRL_START] && !busy;
  assign w_prod   = {{WIDTH{1'b0}}, r_q} * {{WIDTH{1'b0}}, r_opb_lat};
  assign done_irq = r_irq;

  gcd_lcm_div #(.WIDTH(WIDTH)) u_div (
    .clk        (clk),
    .reset      (reset),
    .i_start    (w_div_start),
    .i_dividend (r_opa_lat),
    .i_divisor  (r_a),
    .o_quotient (w_quo),
    .o_valid    (w_div_valid)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_div_start = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_start) w_next = ((r_opa == '0) || (r_opb == '0)) ? S_ERR : S_GCD;
      end
      S_GCD: begin
        // Divider takes its first step on the cycle the GCD settles
        if (r_a == r_b) begin
          if (r_op) begin
            w_next      = S_DIV;
            w_div_start = 1'b1;
          end else begin
            w_next = S_DONE;
          end
        end
      end
      S_DIV:   if (w_div_valid) w_next = S_MUL;
      S_MUL:   w_next = S_DONE;
      S_ERR:   w_next = S_DONE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_opa     <= '0;
      r_opb     <= '0;
      r_opa_lat <= '0;
      r_opb_lat <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_q       <= '0;
      r_result  <= '0;
      r_op      <= 1'b0;
      r_err     <= 1'b0;
      r_ovf     <= 1'b0;
      r_irq     <= 1'b0;
    end else begin
      r_irq <= (w_next == S_DONE) && (r_state != S_DONE);
      if (w_wr && !busy && (w_off == c_OFF_OPA)) r_opa <= WIDTH'(WriteData);
      if (w_wr && !busy && (w_off == c_OFF_OPB)) r_opb <= WIDTH'(WriteData);
      if (w_start) begin
        r_op      <= WriteData[c_CTRL_OP];
        r_a       <= r_opa;
        r_b       <= r_opb;
        r_opa_lat <= r_opa;
        r_opb_lat <= r_opb;
        r_err     <= 1'b0;
        r_ovf     <= 1'b0;
      end
      case (r_state)
        S_GCD: begin
          if (r_a > r_b)      r_a <= r_a - r_b;
          else if (r_b > r_a) r_b <= r_b - r_a;
          else if (!r_op)     r_result <= r_a;
        end
        S_DIV: if (w_div_valid) r_q <= w_quo;
        S_MUL: begin
          r_result <= w_prod[WIDTH-1:0];
          r_ovf    <= |w_prod[2*WIDTH-1:WIDTH];
        end
        S_ERR: begin
          r_result <= '0;
          r_err    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    cop_rdata = '0;
    if (cop_hit) begin
      case (w_off)
        c_OFF_OPA:    cop_rdata = 32'(r_opa);
        c_OFF_OPB:    cop_rdata = 32'(r_opb);
        c_OFF_STATUS: begin
          cop_rdata[c_ST_BUSY] = busy;
          cop_rdata[c_ST_DONE] = (r_state == S_DONE);
          cop_rdata[c_ST_ERR]  = r_err;
          cop_rdata[c_ST_OVF]  = r_ovf;
        end
        c_OFF_RESULT: cop_rdata = 32'(r_result);
        default:      ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_gcd_lcm_ctrl.sv
// ------------------------------------------------------------------
// tb_gcd_lcm_ctrl : directed table-driven bench for gcd_lcm_ctrl
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_gcd_lcm_ctrl;

  localparam logic [31:0] c_BASE = 32'h0000_0200;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWrite;
  logic [31:0] DataAdr;
  logic [31:0] WriteData;
  logic        cop_hit;
  logic [31:0] cop_rdata;
  logic        busy;
  logic        done_irq;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] opa;
    logic [31:0] opb;
    logic [31:0] ctrl;
    int          exp_busy;
    logic [31:0] exp_res;
    logic [31:0] exp_st;
  } vec_t;

  vec_t vecs[10];

  gcd_lcm_ctrl #(.BASE_ADDR(c_BASE), .WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .MemWrite  (MemWrite),
    .DataAdr   (DataAdr),
    .WriteData (WriteData),
    .cop_hit   (cop_hit),
    .cop_rdata (cop_rdata),
    .busy      (busy),
    .done_irq  (done_irq)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Called at a negedge; drives for one cycle and returns at the next negedge
  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    MemWrite  = 1'b1;
    DataAdr   = addr;
    WriteData = data;
    @(negedge clk);
    MemWrite  = 1'b0;
  endtask

  task automatic read_reg(input logic [31:0] addr, output logic [31:0] data);
    DataAdr = addr;
    #1;
    data = cop_rdata;
  endtask

  task automatic run_vec(input int idx);
    int          cnt;
    int          irqs;
    logic [31:0] rd;
    bus_write(c_BASE + 32'h00, vecs[idx].opa);
    bus_write(c_BASE + 32'h04, vecs[idx].opb);
    bus_write(c_BASE + 32'h08, vecs[idx].ctrl);
    cnt  = 0;
    irqs = 0;
    while (busy && cnt < 1000) begin
      if (done_irq) irqs++;
      cnt++;
      @(negedge clk);
    end
    for (int k = 0; k < 3; k++) begin
      if (done_irq) irqs++;
      @(negedge clk);
    end
    check($sformatf("v%0d busy_cycles", idx), 32'(cnt), 32'(vecs[idx].exp_busy));
    check($sformatf("v%0d irq_pulses", idx), 32'(irqs), 32'd1);
    read_reg(c_BASE + 32'h10, rd);
    check($sformatf("v%0d result", idx), rd, vecs[idx].exp_res);
    read_reg(c_BASE + 32'h0C, rd);
    check($sformatf("v%0d status", idx), rd, vecs[idx].exp_st);
  endtask

  initial begin
    logic [31:0] rd;
    int          cnt;

    // busy cycles: GCD steps (incl. the equal step), +31 DIV +1 MUL for LCM, 1 for ERR
    vecs[0] = '{32'd12,        32'd18,        32'h1, 3,  32'd6,        32'h2};
    vecs[1] = '{32'd4,         32'd6,         32'h3, 35, 32'd12,       32'h2};
    vecs[2] = '{32'hC000_0000, 32'h8000_0000, 32'h3, 35, 32'h8000_0000, 32'hA};
    vecs[3] = '{32'd12,        32'd18,        32'h1, 3,  32'd6,        32'h2};
    vecs[4] = '{32'd0,         32'd7,         32'h1, 1,  32'd0,        32'h6};
    vecs[5] = '{32'd100,       32'd75,        32'h1, 4,  32'd25,       32'h2};
    vecs[6] = '{32'd7,         32'd7,         32'h3, 33, 32'd7,        32'h2};
    vecs[7] = '{32'd3,         32'd5,         32'h3, 36, 32'd15,       32'h2};
    vecs[8] = '{32'd5,         32'd0,         32'h3, 1,  32'd0,        32'h6};
    vecs[9] = '{32'h0001_0000, 32'h0003_0000, 32'h3, 35, 32'h0003_0000, 32'h2};

    reset     = 1'b0;
    MemWrite  = 1'b0;
    DataAdr   = c_BASE;
    WriteData = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst irq", {31'd0, done_irq}, 32'd0);
    read_reg(c_BASE + 32'h0C, rd); check("rst status", rd, 32'h0);
    read_reg(c_BASE + 32'h10, rd); check("rst result", rd, 32'h0);
    read_reg(c_BASE + 32'h00, rd); check("rst opa", rd, 32'h0);
    @(negedge clk);

    for (int i = 0; i < 10; i++) run_vec(i);

    read_reg(c_BASE + 32'h04, rd); check("opb readback", rd, 32'h0003_0000);
    read_reg(c_BASE + 32'h08, rd); check("ctrl reads 0", rd, 32'h0);
    read_reg(c_BASE + 32'h14, rd); check("unused offset rdata", rd, 32'h0);
    check("unused offset hit", {31'd0, cop_hit}, 32'd1);
    @(negedge clk);

    // Writes to OPA and CTRL while a GCD is running must be dropped
    bus_write(c_BASE + 32'h00, 32'd12);
    bus_write(c_BASE + 32'h04, 32'd18);
    bus_write(c_BASE + 32'h08, 32'h1);
    bus_write(c_BASE + 32'h00, 32'd99);
    bus_write(c_BASE + 32'h08, 32'h1);
    cnt = 0;
    while (busy && cnt < 1000) begin
      cnt++;
      @(negedge clk);
    end
    check("prot busy_cycles", 32'(cnt), 32'd1);
    read_reg(c_BASE + 32'h10, rd); check("prot result", rd, 32'd6);
    read_reg(c_BASE + 32'h00, rd); check("prot opa", rd, 32'd12);
    read_reg(c_BASE + 32'h0C, rd); check("prot status", rd, 32'h2);
    @(negedge clk);

    // Asynchronous reset in the middle of an LCM divide
    bus_write(c_BASE + 32'h00, 32'd4);
    bus_write(c_BASE + 32'h04, 32'd6);
    bus_write(c_BASE + 32'h08, 32'h3);
    repeat (10) @(negedge clk);
    check("mid busy before rst", {31'd0, busy}, 32'd1);
    #2 reset = 1'b0;
    #1 check("mid busy in rst", {31'd0, busy}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("mid busy after rst", {31'd0, busy}, 32'd0);
    read_reg(c_BASE + 32'h0C, rd); check("mid status", rd, 32'h0);
    read_reg(c_BASE + 32'h10, rd); check("mid result", rd, 32'h0);
    read_reg(c_BASE + 32'h00, rd); check("mid opa", rd, 32'h0);
    read_reg(32'h0000_0220, rd); check("outside hi rdata", rd, 32'h0);
    check("outside hi hit", {31'd0, cop_hit}, 32'd0);
    read_reg(32'h0000_01FC, rd); check("outside lo rdata", rd, 32'h0);
    check("outside lo hit", {31'd0, cop_hit}, 32'd0);
    cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (busy || done_irq) cnt++;
    end
    check("idle after rst", 32'(cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
